// File: rtl/axil_pkg.sv
// axil_pkg: AXI-Lite response codes, write-FSM states and register index width helper
package axil_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {IDLE, ADDR_HELD, DATA_HELD, RESP} wr_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axil_addr_decode.sv
// axil_addr_decode: byte address to register index, flagging out-of-range or misaligned addresses
module axil_addr_decode import axil_pkg::*; #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = idx_w(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  err
);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int IW  = ADDR_WIDTH - OFF;
  localparam logic [IW:0] NR = NUM_REGS[IW:0];
  logic [IW-1:0] full;
  assign full = addr[ADDR_WIDTH-1:OFF];
  assign idx  = full[IDX_W-1:0];
  assign err  = ({1'b0, full} >= NR) || (|addr[OFF-1:0]);
endmodule

// File: rtl/axil_write_ctrl.sv
// axil_write_ctrl: AXI4-Lite write-channel slave driving a one-cycle register write strobe.
// Define AXIL_WR_STRB_EN to forward wstrb; otherwise every write is full-word.
module axil_write_ctrl import axil_pkg::*; #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = idx_w(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    wr_en,
  output logic [IDX_W-1:0]        wr_idx,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb
);
  localparam int STRB_W = DATA_WIDTH / 8;
  wr_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_sel;
  logic [DATA_WIDTH-1:0] data_q, data_sel;
  logic [STRB_W-1:0] strb_sel;
  logic [IDX_W-1:0] idx;
  logic aw_hs, w_hs, go, err;
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign bvalid   = state == RESP;
  assign addr_sel = state == ADDR_HELD ? addr_q : awaddr;
  assign data_sel = state == DATA_HELD ? data_q : wdata;
  assign go       = state != RESP && state_n == RESP;
`ifdef AXIL_WR_STRB_EN
  logic [STRB_W-1:0] strb_q;
  assign strb_sel = state == DATA_HELD ? strb_q : wstrb;
  always_ff @(posedge clk)
    if (w_hs) strb_q <= wstrb;
`else
  // strobes are ignored: every write covers the whole word
  assign strb_sel = wstrb | {STRB_W{1'b1}};
`endif
  axil_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
  ) u_dec (.addr(addr_sel), .idx(idx), .err(err));
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = aw_hs && w_hs ? RESP : aw_hs ? ADDR_HELD : w_hs ? DATA_HELD : IDLE;
      ADDR_HELD: state_n = w_hs ? RESP : ADDR_HELD;
      DATA_HELD: state_n = aw_hs ? RESP : DATA_HELD;
      RESP:      state_n = bready ? IDLE : RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (aw_hs) addr_q <= awaddr;
    if (w_hs) data_q <= wdata;
  end
  // readies are registered from the next state so they stay low through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bresp   <= AXI_RESP_OKAY;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      state   <= state_n;
      awready <= state_n == IDLE || state_n == DATA_HELD;
      wready  <= state_n == IDLE || state_n == ADDR_HELD;
      wr_en   <= go && !err;
      if (go) bresp <= err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      if (go && !err) begin
        wr_idx  <= idx;
        wr_data <= data_sel;
        wr_strb <= strb_sel;
      end
    end
  end
endmodule
